// File: rtl/dpram_if_pkg.sv
// dpram_if_pkg: shared constants and response record for the block-RAM request bridge
package dpram_if_pkg;
  localparam int BYTE_LANES = 4;
  localparam int DATA_W = 8 * BYTE_LANES;
  localparam int DEF_VECTOR_LENGTH = 512;
  localparam int DEF_ADDR_WIDTH = 9;
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic err;
  } rsp_t;
endpackage

// File: rtl/dpram_rsp_fifo.sv
// dpram_rsp_fifo: synchronous response FIFO with wrapping pointers and occupancy count
module dpram_rsp_fifo
  import dpram_if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  logic        pop,
  input  rsp_t        din,
  output rsp_t        dout,
  output logic [PW:0] count,
  output logic        full,
  output logic        empty
);
  rsp_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= din;
  end
endmodule

// File: rtl/dpram_req_bridge.sv
// dpram_req_bridge: request/response bridge onto a registered-read block-RAM port with credit-limited read buffering
module dpram_req_bridge
  import dpram_if_pkg::*;
#(
  parameter int VECTOR_LENGTH = DEF_VECTOR_LENGTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH = DATA_W,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WORD_WIDTH-1:0] req_wdata_i,
  input  logic [BYTE_LANES-1:0] req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WORD_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  err_o,
  output logic                  mem_clke_o,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  output logic [BYTE_LANES-1:0] mem_wbytemask_o,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i
);
  logic inflight, inflight_err, in_range, wr_fire, rd_fire, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [ADDR_WIDTH-1:0] raddr_q, waddr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [BYTE_LANES-1:0] be_q;
  rsp_t head, din;
  assign in_range = 32'(req_addr_i) < 32'(VECTOR_LENGTH);
  assign req_ready_o = !rst_i && (req_we_i || ({1'b0, count} + (CW+1)'(inflight) < (CW+1)'(FIFO_DEPTH)));
  assign wr_fire = req_valid_i && req_ready_o && req_we_i;
  assign rd_fire = req_valid_i && req_ready_o && !req_we_i;
  assign mem_clke_o = !rst_i;
  assign mem_we_o = wr_fire && in_range;
  assign mem_re_o = rd_fire && in_range;
  assign mem_raddr_o = rd_fire ? req_addr_i : raddr_q;
  assign mem_waddr_o = wr_fire ? req_addr_i : waddr_q;
  assign mem_wdata_o = wr_fire ? req_wdata_i : wdata_q;
  assign mem_wbytemask_o = wr_fire ? req_be_i : be_q;
  assign push = inflight;
  assign din = '{rdata: inflight_err ? '0 : mem_rdata_i, err: inflight_err};
  assign rsp_valid_o = !empty;
  assign pop = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = empty ? '0 : head.rdata;
  assign rsp_err_o = !empty && head.err;
  dpram_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      inflight_err <= 1'b0;
      err_o <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      inflight <= rd_fire;
      inflight_err <= rd_fire && !in_range;
      if (wr_fire && !in_range) err_o <= 1'b1;
      if (rd_fire) raddr_q <= req_addr_i;
      if (wr_fire) begin
        waddr_q <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q <= req_be_i;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push && full && !pop));
  end
endmodule

// File: tb/tb_dpram_req_bridge.sv
// tb_dpram_req_bridge: directed stimulus against a queue-based reference of the bridge and a RAM model
module tb_dpram_req_bridge;
  localparam int AW = 10;
  localparam int VL = 512;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_be = '0;
  logic req_ready_o, rsp_valid_o, rsp_err_o, err_o, mem_clke_o, mem_re_o, mem_we_o;
  logic [31:0] rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] mem_raddr_o, mem_waddr_o;
  logic [3:0] mem_wbytemask_o;
  int checks = 0, errors = 0, cyc = 0, pops = 0;
  logic [31:0] ram [VL];
  logic [31:0] ref_mem [VL];
  logic model_err = 0;
  typedef struct { int t; logic [31:0] d; logic e; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  dpram_req_bridge #(.VECTOR_LENGTH(VL), .ADDR_WIDTH(AW), .WORD_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .err_o(err_o), .mem_clke_o(mem_clke_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_we_o(mem_we_o),
    .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o), .mem_wbytemask_o(mem_wbytemask_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    for (int i = 0; i < VL; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    mem_rdata_i = '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clke_o && mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_wbytemask_o[b]) ram[mem_waddr_o[8:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    if (mem_clke_o && mem_re_o) mem_rdata_i <= ram[mem_raddr_o[8:0]];
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic exp_ready, acc, inr, ev;
    exp_ready = !rst && (req_we || q.size() < 4);
    chk("req_ready", req_ready_o, exp_ready);
    acc = req_valid && exp_ready;
    inr = req_addr < AW'(VL);
    chk("mem_we", mem_we_o, acc && req_we && inr);
    chk("mem_re", mem_re_o, acc && !req_we && inr);
    chk("mem_clke", mem_clke_o, !rst);
    if (mem_we_o && acc && req_we && inr)
      chk("wport", {mem_waddr_o, mem_wdata_o, mem_wbytemask_o}, {req_addr, req_wdata, req_be});
    if (mem_re_o && acc && !req_we && inr) chk("raddr", mem_raddr_o, req_addr);
    if (rst) begin
      q.delete();
      model_err = 0;
    end else begin
      ev = q.size() > 0 && cyc >= q[0].t + 2;
      chk("rsp_valid", rsp_valid_o, ev);
      if (ev) chk("rsp_data", {rsp_err_o, rsp_rdata_o}, {q[0].e, q[0].d});
      chk("err_o", err_o, model_err);
      if (ev && rsp_ready) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc) begin
        if (req_we) begin
          if (inr) begin
            for (int b = 0; b < 4; b++)
              if (req_be[b]) ref_mem[req_addr[8:0]][8*b +: 8] = req_wdata[8*b +: 8];
          end else model_err = 1;
        end else q.push_back('{t: cyc, d: inr ? ref_mem[req_addr[8:0]] : 32'h0, e: !inr});
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        @(posedge clk); #1;
        req_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    errors++;
    $display("FAIL send_timeout addr %h never accepted", a);
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_n, p0, c0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rdata", {rsp_err_o, rsp_rdata_o}, 0);
    chk("rst_mem_en", {mem_re_o, mem_we_o, mem_clke_o}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_err", err_o, 0);
    @(posedge clk); #1;

    send(1, 10'h005, 32'hDEADBEEF, 4'hF);
    send(0, 10'h005, 0, 0);
    @(negedge clk);
    chk("lat_t1_valid", rsp_valid_o, 0);
    @(negedge clk);
    chk("lat_t2_valid", rsp_valid_o, 1);
    chk("rd_deadbeef", {rsp_err_o, rsp_rdata_o}, {1'b0, 32'hDEADBEEF});
    idle(2);

    send(1, 10'h010, 32'h11223344, 4'hF);
    send(1, 10'h010, 32'hAABBCCDD, 4'b0101);
    send(0, 10'h010, 0, 0);
    repeat (2) @(negedge clk);
    chk("rd_bytemask", {rsp_err_o, rsp_rdata_o}, {1'b0, 32'h11BB33DD});
    idle(2);

    for (int i = 0; i < 8; i++) send(1, AW'(i), 32'h01010101 * (i + 1), 4'hF);
    for (int i = 0; i < 6; i++) send(1, AW'(10'h20 + i), 32'hC0DE0000 + i, 4'hF);
    idle(2);
    p0 = pops; c0 = cyc;
    for (int i = 0; i < 8; i++) send(0, AW'(i), 0, 0);
    chk("burst_cycles", cyc - c0, 8);
    idle(6);
    chk("burst_rsps", pops - p0, 8);

    rsp_ready = 0;
    p0 = pops; acc_n = 0;
    req_valid = 1; req_we = 0;
    repeat (10) begin
      req_addr = AW'(10'h20 + acc_n);
      @(negedge clk);
      if (req_ready_o) acc_n++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc_n, 4);
    @(negedge clk);
    chk("bp_read_blocked", req_ready_o, 0);
    @(posedge clk); #1;
    req_we = 1; req_addr = 10'h030; req_wdata = 32'h55AA55AA; req_be = 4'hF;
    @(negedge clk);
    chk("bp_write_ok", req_ready_o, 1);
    @(posedge clk); #1;
    req_valid = 0;
    rsp_ready = 1;
    send(0, 10'h024, 0, 0);
    send(0, 10'h025, 0, 0);
    idle(6);
    chk("bp_rsps", pops - p0, 6);

    send(0, 10'h200, 0, 0);
    repeat (2) @(negedge clk);
    chk("oor_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {2'b11, 32'h0});
    @(posedge clk); #1;
    send(1, 10'h200, 32'hBAD0BAD0, 4'hF);
    @(negedge clk);
    chk("oor_err", err_o, 1);
    idle(3);
    @(negedge clk);
    chk("oor_err_sticky", err_o, 1);
    @(posedge clk); #1;

    send(0, 10'h005, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_flush_valid", rsp_valid_o, 0);
    end
    chk("rst_flush_err", err_o, 0);
    chk("rst_flush_count", dut.count, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_req_bridge.md
Name: dpram_req_bridge

Overview:
- Initiator-side controller for the block-RAM port interface.
- Accepts a single valid/ready request stream of 32-bit reads and writes with byte enables, and drives the RAM read and write ports.
- Absorbs the RAM's one-cycle registered read latency and returns read data on a valid/ready response stream.
- Credit-limited buffering guarantees that no read data is lost under response backpressure.
- Sits between a fabric bus master (e.g. the USB bridge) and the RAM macro.

Parameters:
- VECTOR_LENGTH, 512, number of RAM words; addresses at or above this are out of range.
- ADDR_WIDTH, 9, request and RAM address width.
- WORD_WIDTH, 32, data width; must equal 4 bytes to match the byte mask.
- FIFO_DEPTH, 4, response buffer entries; minimum 2, power of two.

Ports:
- clk_i  in  1  single clock; the RAM's rclk_i and wclk_i are tied to it externally.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  word address.
- req_wdata_i  in  WORD_WIDTH  write data.
- req_be_i  in  4  byte enables for writes.
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_rdata_o  out  WORD_WIDTH  read data.
- rsp_err_o  out  1  response is for an out-of-range read.
- err_o  out  1  sticky: an out-of-range write was dropped.
- mem_clke_o  out  1  drives the RAM rclke_i and wclke_i.
- mem_re_o  out  1  RAM read enable.
- mem_raddr_o  out  ADDR_WIDTH  RAM read address.
- mem_we_o  out  1  RAM write enable.
- mem_waddr_o  out  ADDR_WIDTH  RAM write address.
- mem_wdata_o  out  WORD_WIDTH  RAM write data.
- mem_wbytemask_o  out  4  RAM byte mask.
- mem_rdata_i  in  WORD_WIDTH  RAM read data.

Behaviour:
- Reset (clk_i edge with rst_i=1):
  - FIFO emptied, in-flight flag cleared, err_o=0.
  - req_ready_o=0, rsp_valid_o=0, mem_re_o=0, mem_we_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - A read in flight when reset is applied is discarded.
  - req_ready_o stays 0 for the whole cycle in which rst_i is high.
- mem_clke_o is 1 whenever rst_i=0.
- Accept rule:
  - Writes: req_ready_o=1 whenever not in reset.
  - Reads: req_ready_o=1 only if fifo_count + inflight < FIFO_DEPTH, evaluated on registered state. A same-cycle pop does not grant credit.
- Accepted write in cycle T:
  - mem_we_o=1 combinationally in T, with mem_waddr_o/wdata_o/wbytemask_o taken straight from the request.
  - No response is produced.
  - If req_addr_i >= VECTOR_LENGTH, mem_we_o stays 0 and err_o is set on the edge ending T.
- Accepted read in cycle T:
  - mem_re_o=1 and mem_raddr_o=req_addr_i combinationally in T.
  - The inflight register is set on the edge ending T.
  - In T+1, mem_rdata_i is captured into the FIFO.
  - rsp_valid_o=1 from T+2 at the earliest (load-to-use latency 2).
- Out-of-range read:
  - mem_re_o stays 0, but the read still occupies a slot.
  - Its response is pushed with rdata=0 and rsp_err_o=1, in order.
- Response ordering is strict FIFO order. Ordering between reads and writes follows acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- FIFO behaviour:
  - Push and pop in the same cycle are both allowed.
  - Pointers wrap modulo FIFO_DEPTH.
  - The credit rule makes overflow impossible; an overflow assertion is required in simulation.
- Idle: mem_re_o=mem_we_o=0, address and data outputs are don't-care but held at their last value.
- Throughput: a read every cycle with rsp_ready_i=1 continuously when FIFO_DEPTH>=4. Writes run at 1 per cycle always.

Decomposition:
- Package dpram_if_pkg:
  - BYTE_LANES=4.
  - rsp_t struct {rdata, err}.
  - Default VECTOR_LENGTH and ADDR_WIDTH constants shared with the RAM wrapper.
- Sub-module dpram_rsp_fifo:
  - Synchronous FIFO of rsp_t.
  - Ports: push, pop, count, full, empty.

Test Plan:
- Reset then write addr 0x005, data 0xDEADBEEF, be 4'b1111; then read 0x005 -> rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid_o 2 cycles after read acceptance.
- Write 0x010 = 0x11223344, then write 0x010 = 0xAABBCCDD with be 4'b0101; read -> 0x11BB33DD.
- Back-to-back reads of 0x000..0x007 with rsp_ready_i=1 -> 8 responses, in order, on consecutive cycles, req_ready_o never low.
- Hold rsp_ready_i=0 and issue 6 reads -> exactly 4 accepted, req_ready_o=0 afterwards, writes still accepted; release -> 4 correct responses, then the remaining reads are accepted.
- Read 0x200 and write 0x1FF+1 (VECTOR_LENGTH=512) -> rsp_err_o=1 with rdata=0; err_o=1 sticky; mem_we_o never asserted for the write.
- Assert rst_i one cycle after a read is accepted -> no response ever appears, rsp_valid_o=0, err_o=0, FIFO count 0.
